rr_reg_arbiter: RTL and testbench
=================================

RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every requester and of the shared register.
REQ-002 Parameter NUM_REQ, default 4 (range 2..16), SHALL set the number of requesters.
REQ-003 Parameter MAX_HOLD, default 4 (range 1..255), SHALL set the maximum consecutive writes per grant.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req  input  NUM_REQ  SHALL carry per-requester write request; bit i belongs to requester i.
REQ-007 lock  input  NUM_REQ  SHALL carry per-requester burst-hold request; it is meaningful only with req.
REQ-008 data  input  NUM_REQ x WIDTH  SHALL carry per-requester write data.
REQ-009 gnt  output  NUM_REQ  SHALL be the registered, one-hot-or-zero grant vector.
REQ-010 out  output  WIDTH  SHALL be the shared register contents.
REQ-011 out_valid  output  1  SHALL be high for one cycle after each cycle in which out was written.
REQ-012 owner  output  clog2(NUM_REQ)  SHALL hold the index of the last granted requester.

Function
REQ-013 FSM SHALL have exactly two states, IDLE and HELD.
REQ-014 In IDLE with any req bit high, the edge SHALL:
- select the winner by round-robin from pointer ptr;
- set gnt to one-hot(winner), owner to winner, out to data[winner], and out_valid to 1;
- set ptr to (winner+1) mod NUM_REQ.
REQ-015 In IDLE with req all zero, the block SHALL hold out, keep gnt at 0, and drive out_valid to 0.
REQ-016 Round-robin search SHALL start at ptr and wrap from NUM_REQ-1 to 0; the lowest index at or after ptr wins.
REQ-017 In IDLE, a winner with lock high and MAX_HOLD>1 SHALL move the FSM to HELD with hold_cnt=1; otherwise the FSM stays IDLE and gnt is cleared at the next edge.
REQ-018 In HELD, when req[owner], lock[owner] and hold_cnt<MAX_HOLD are all true, the edge SHALL write out<=data[owner], increment hold_cnt, keep gnt, and set out_valid to 1.
REQ-019 In HELD, when any condition of REQ-018 is false, the edge SHALL:
- clear gnt and set out_valid to 0;
- return the FSM to IDLE, leaving out unchanged.
This produces one bubble cycle before the next arbitration.
REQ-020 Requests from non-owners during HELD SHALL be ignored and SHALL NOT change ptr.
REQ-021 Write latency SHALL be: req sampled at edge k, out updated at edge k and visible in cycle k+1; no combinational path from req to gnt or out.
REQ-022 Within a single grant, one requester SHALL receive at most MAX_HOLD consecutive writes.
REQ-023 gnt SHALL never have more than one bit set.

Reset
REQ-024 rst_n low SHALL immediately set out=0, gnt=0, out_valid=0, owner=0, ptr=0, hold_cnt=0 and state=IDLE, regardless of clk.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from ptr=0.
REQ-026 The first edge after rst_n rises SHALL arbitrate normally.

Structure
REQ-027 The state enum (IDLE, HELD) and a clog2-based index-width function SHALL live in package rr_reg_arbiter_pkg.
REQ-028 The shared register SHALL be one sub-module, reg_en_n: a WIDTH-bit register with enable and asynchronous active-low reset to 0, driven by a write-enable and a muxed data input.
REQ-029 Arbitration, FSM and counter logic SHALL reside in rr_reg_arbiter.

Verification
REQ-030 Reset state: drive rst_n=0 mid-cycle -> out=0, gnt=0 and out_valid=0 immediately, without waiting for an edge.
REQ-031 Round-robin fairness: req=4'b1111, lock=0, data[i]=8'h10+i -> grants 0,2,0,2... is wrong; the sequence SHALL be 0,1,2,3,0 with one bubble between grants and out following 8'h10,8'h11,8'h12,8'h13.
REQ-032 Burst cap: MAX_HOLD=4, req[1]=lock[1]=1 held, data[1]=8'hA5 -> out_valid high for exactly 4 edges with gnt=4'b0010, then gnt=0 for one cycle.
REQ-033 Early release: req[2]=lock[2]=1, lock[2] dropped after 2 writes -> 2 writes, then IDLE; req[3] arriving during HELD is granted next with ptr=3.
REQ-034 Wrap-around: ptr=3 with req=4'b1001 -> requester 3 wins, ptr becomes 0, and requester 0 wins the next arbitration.
REQ-035 Reset mid-burst: rst_n low during the 2nd HELD write -> out=0 and gnt=0; after release with req=4'b0100, requester 2 is granted and ptr=3.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package rr_reg_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/reg_en_n.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module reg_en_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters write access to one shared
// register, with optional lock-driven bursts capped at MAX_HOLD writes.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned IDX_W    = idx_w(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [WIDTH-1:0]                out,
    output logic                            out_valid,
    output logic [IDX_W-1:0]                owner
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;

    logic               found_c;
    logic [IDX_W-1:0]   winner_c;
    logic               wr_en_c;
    logic [IDX_W-1:0]   wr_sel_c;

    // First requester at or after ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        found_c  = 1'b0;
        winner_c = '0;
        idx      = 0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!found_c && req[cand]) begin
                found_c  = 1'b1;
                winner_c = cand;
            end
        end
    end

    // Next state; IDLE only arbitrates once the previous grant has dropped,
    // which gives the single bubble cycle between grants.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        hold_d   = hold_q;
        valid_d  = 1'b0;
        wr_en_c  = 1'b0;
        wr_sel_c = owner_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if ((gnt_q == '0) && found_c) begin
                    wr_en_c  = 1'b1;
                    wr_sel_c = winner_c;
                    valid_d  = 1'b1;
                    gnt_d    = NUM_REQ'(1) << winner_c;
                    owner_d  = winner_c;
                    ptr_d    = (32'(winner_c) == NUM_REQ - 1) ? '0 : winner_c + 1'b1;
                    if (lock[winner_c] && (MAX_HOLD > 1)) begin
                        state_d = HELD;
                        hold_d  = CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (req[owner_q] && lock[owner_q] && (hold_q < CNT_W'(MAX_HOLD))) begin
                    wr_en_c = 1'b1;
                    valid_d = 1'b1;
                    gnt_d   = gnt_q;
                    hold_d  = hold_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    reg_en_n #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en_c),
        .d     (data[wr_sel_c]),
        .q     (out)
    );

    assign gnt       = gnt_q;
    assign out_valid = valid_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with hand-computed expected vectors.
module tb_rr_reg_arbiter;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      lock;
    logic [3:0][7:0] data;
    logic [3:0]      gnt;
    logic [7:0]      out;
    logic            out_valid;
    logic [1:0]      owner;
    logic [14:0]     obs;

    int n_cmp;
    int n_err;

    rr_reg_arbiter #(
        .WIDTH    (8),
        .NUM_REQ  (4),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .data      (data),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid),
        .owner     (owner)
    );

    assign obs = {gnt, out, out_valid, owner};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        data  = '0;
        tick();
        tick();
        n_cmp++;
        if (obs !== 15'd0) begin
            n_err++;
            $display("FAIL reset_hold: got gnt=%b out=%h ov=%b owner=%0d, expected all zero",
                     gnt, out, out_valid, owner);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] exp [5];
        exp = '{ {4'b0000, 8'h00, 1'b0, 2'd0},
                 {4'b0001, 8'h5A, 1'b1, 2'd0},
                 {4'b0000, 8'h5A, 1'b0, 2'd0},
                 {4'b0010, 8'h77, 1'b1, 2'd1},
                 {4'b0010, 8'h77, 1'b1, 2'd1} };
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                req     = 4'b0001;
                data[0] = 8'h5A;
            end
            if (i == 2) begin
                req     = 4'b0010;
                lock    = 4'b0010;
                data[1] = 8'h77;
            end
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL reset_seq step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 15'd0) begin
            n_err++;
            $display("FAIL reset_async: got gnt=%b out=%h ov=%b owner=%0d, expected all zero",
                     gnt, out, out_valid, owner);
        end
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== exp[4]) begin
            n_err++;
            $display("FAIL reset_first_edge: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=0010 out=77 ov=1 owner=1",
                     gnt, out, out_valid, owner);
        end
    endtask

    task automatic test_fairness();
        logic [14:0] exp [9];
        exp = '{ {4'b0001, 8'h10, 1'b1, 2'd0},
                 {4'b0000, 8'h10, 1'b0, 2'd0},
                 {4'b0010, 8'h11, 1'b1, 2'd1},
                 {4'b0000, 8'h11, 1'b0, 2'd1},
                 {4'b0100, 8'h12, 1'b1, 2'd2},
                 {4'b0000, 8'h12, 1'b0, 2'd2},
                 {4'b1000, 8'h13, 1'b1, 2'd3},
                 {4'b0000, 8'h13, 1'b0, 2'd3},
                 {4'b0001, 8'h10, 1'b1, 2'd0} };
        do_reset();
        req  = 4'b1111;
        lock = 4'b0000;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL fairness step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [14:0] exp [6];
        exp = '{ {4'b0010, 8'hA5, 1'b1, 2'd1},
                 {4'b0010, 8'hA6, 1'b1, 2'd1},
                 {4'b0010, 8'hA7, 1'b1, 2'd1},
                 {4'b0010, 8'hA8, 1'b1, 2'd1},
                 {4'b0000, 8'hA8, 1'b0, 2'd1},
                 {4'b0010, 8'hAA, 1'b1, 2'd1} };
        do_reset();
        req  = 4'b0010;
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            data[1] = 8'(8'hA5 + i);
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL burst_cap step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
        end
    endtask

    task automatic test_early_release();
        logic [14:0] exp [6];
        logic [3:0]  rq  [6];
        logic [3:0]  lk  [6];
        logic [7:0]  d2  [6];
        exp = '{ {4'b0100, 8'hC0, 1'b1, 2'd2},
                 {4'b0100, 8'hC1, 1'b1, 2'd2},
                 {4'b0000, 8'hC1, 1'b0, 2'd2},
                 {4'b1000, 8'hD3, 1'b1, 2'd3},
                 {4'b0000, 8'hD3, 1'b0, 2'd3},
                 {4'b0100, 8'hC2, 1'b1, 2'd2} };
        rq  = '{4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100};
        lk  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        d2  = '{8'hC0, 8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC2};
        do_reset();
        data[3] = 8'hD3;
        for (int i = 0; i < 6; i++) begin
            req     = rq[i];
            lock    = lk[i];
            data[2] = d2[i];
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL early_release step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [14:0] exp [5];
        exp = '{ {4'b0100, 8'h22, 1'b1, 2'd2},
                 {4'b0000, 8'h22, 1'b0, 2'd2},
                 {4'b1000, 8'h23, 1'b1, 2'd3},
                 {4'b0000, 8'h23, 1'b0, 2'd3},
                 {4'b0001, 8'h20, 1'b1, 2'd0} };
        do_reset();
        data = {8'h23, 8'h22, 8'h21, 8'h20};
        req  = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req = 4'b1001;
            end
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL wrap step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [14:0] exp [5];
        exp = '{ {4'b0100, 8'hE0, 1'b1, 2'd2},
                 {4'b0100, 8'hE1, 1'b1, 2'd2},
                 {4'b0100, 8'hE2, 1'b1, 2'd2},
                 {4'b0000, 8'hE2, 1'b0, 2'd2},
                 {4'b1000, 8'hF3, 1'b1, 2'd3} };
        do_reset();
        req     = 4'b0100;
        lock    = 4'b0100;
        data[2] = 8'hE0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL mid_burst step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
            data[2] = 8'hE1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 15'd0) begin
            n_err++;
            $display("FAIL mid_burst_reset: got gnt=%b out=%h ov=%b owner=%0d, expected all zero",
                     gnt, out, out_valid, owner);
        end
        lock    = 4'b0000;
        data[2] = 8'hE2;
        data[3] = 8'hF3;
        #2;
        rst_n = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp[i]) begin
                n_err++;
                $display("FAIL mid_burst step %0d: got gnt=%b out=%h ov=%b owner=%0d, expected gnt=%b out=%h ov=%b owner=%0d",
                         i, gnt, out, out_valid, owner, exp[i][14:11], exp[i][10:3], exp[i][2], exp[i][1:0]);
            end
            req = 4'b1100;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        data  = '0;
        test_reset();
        test_fairness();
        test_burst_cap();
        test_early_release();
        test_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
